word_serializer: RTL and testbench
==================================

Name: word_serializer

Overview:
- Parallel-in, serial-out companion to the team's clocked parallel register.
- Accepts a (WIREWIDTH+1)-bit word over a valid/ready handshake and shifts it out one bit per clock, LSB first, with first/last framing strobes.
- Used in schematic designs wherever a registered bus must be sent over a single wire to a serial capture stage.

Parameters:
- WIREWIDTH, 7, MSB index of the data word; the word width is WIREWIDTH+1 (legal range 0..31).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- d  input  [WIREWIDTH:0]  parallel word to send
- d_valid  input  1  d holds a word to transfer
- d_ready  output  1  block accepts d on this edge
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a data bit this cycle
- sout_first  output  1  sout is bit 0 of a word
- sout_last  output  1  sout is bit WIREWIDTH of a word
- busy  output  1  a word is in flight

Behaviour:
- Reset (rst_n low, asynchronous, no clock required):
  - State returns to IDLE.
  - sout, sout_valid, sout_first, sout_last and busy are 0.
  - The shift register and bit counter are cleared.
  - Any in-flight word is discarded; no partial word resumes after reset release.
- All serial outputs and busy are registered. d_ready is combinational from state and counter only, never from d_valid.
- States:
  - IDLE: d_ready=1, sout_valid=0.
  - SHIFT: a word is being sent; busy=1.
- Transfer: occurs on a rising edge where d_valid=1 and d_ready=1. The word is loaded into the shift register, the counter is set to 0, and the state goes to SHIFT.
- Latency: bit 0 appears on sout in the cycle immediately after the accepting edge, with sout_valid=1 and sout_first=1.
- Each SHIFT cycle presents one bit and the counter increments. Bit k is presented in cycle k after acceptance (k=0..WIREWIDTH).
- sout_last=1 while the counter equals WIREWIDTH.
- d_ready in SHIFT is 1 only in the sout_last cycle:
  - A transfer on that edge loads the next word, so back-to-back words stream with no gap.
  - Otherwise the state returns to IDLE and sout_valid drops to 0 on the next cycle.
- d_valid without d_ready: no effect. d may change freely; only the value at the accepting edge is sent.
- WIREWIDTH=0: each word is one cycle with sout_first=sout_last=1; d_ready stays 1 throughout continuous streaming.
- Counter width is clog2(WIREWIDTH+1), minimum 1 bit. The counter never wraps past WIREWIDTH.
- In IDLE, sout is driven 0.
- Throughput: 1 bit/clock sustained; a word takes exactly WIREWIDTH+1 cycles.

Test Plan:
- WIREWIDTH=7: reset, then d=8'hA5 with a 1-cycle d_valid pulse.
  - Next 8 cycles: sout = 1,0,1,0,0,1,0,1 with sout_valid=1.
  - sout_first only in cycle 1; sout_last only in cycle 8.
  - busy=0 and d_ready=1 from cycle 9.
- Back-to-back streaming: d_valid held high; d=8'h01, then 8'hFF presented at the sout_last edge.
  - Output is 16 contiguous valid bits: 1,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1.
  - sout_first appears at bits 0 and 8; no gap cycle.
- Handshake hold-off: during SHIFT, drive d_valid=1 with d=8'h3C in bit cycles 2-5.
  - d_ready=0 in those cycles; no new load occurs.
  - The current word completes unaltered.
- Reset mid-operation: assert rst_n=0 asynchronously, between clock edges, during bit 4 of 8'hF0.
  - All outputs go to 0 immediately.
  - After release, sout_valid stays 0 until a new transfer.
  - A new word 8'h0F serializes cleanly from bit 0.
- WIREWIDTH=0: d alternating 1,0,1 with d_valid held.
  - sout = 1,0,1 on consecutive cycles.
  - sout_first=sout_last=1 each cycle; d_ready constantly 1.

Source files
------------

// File: rtl/word_serializer.sv
// word_serializer: parallel-in, serial-out shifter.
// Accepts a (WIREWIDTH+1)-bit word over a valid/ready handshake and
// presents it LSB first, one bit per clock. The output carries first/last
// framing strobes. All serial outputs and busy are registered.
// d_ready is decoded from state and counter only.

module word_serializer #(
    parameter int WIREWIDTH = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIREWIDTH:0] d,
    input  logic               d_valid,
    output logic               d_ready,
    output logic               sout,
    output logic               sout_valid,
    output logic               sout_first,
    output logic               sout_last,
    output logic               busy
);

    // Counter width: enough to hold 0..WIREWIDTH, never narrower than 1 bit.
    localparam int CW = (WIREWIDTH < 1) ? 1 : $clog2(WIREWIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIREWIDTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIREWIDTH:0] r_shift;
    logic [CW-1:0]      r_cnt;
    logic               r_sout;
    logic               r_sout_valid;
    logic               r_sout_first;
    logic               r_sout_last;
    logic               r_busy;

    logic [WIREWIDTH:0] w_shift_next;
    logic [WIREWIDTH:0] w_shift_dn;
    logic [CW-1:0]      w_cnt_next;
    logic [CW-1:0]      w_cnt_inc;
    logic               w_sout_next;
    logic               w_sout_valid_next;
    logic               w_sout_first_next;
    logic               w_sout_last_next;
    logic               w_busy_next;
    logic               w_at_last;
    logic               w_ready;
    logic               w_xfer;

    // The word being shifted always has its next bit at position 0.
    assign w_shift_dn = r_shift >> 1;
    assign w_cnt_inc  = r_cnt + CW'(1);

    // The counter tracks the bit currently on sout, so "last" is a counter compare.
    assign w_at_last = (r_state == ST_SHIFT) && (r_cnt == LAST_IDX);
    assign w_ready   = (r_state == ST_IDLE) || w_at_last;
    assign w_xfer    = d_valid && w_ready;

    assign d_ready    = w_ready;
    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign sout_first = r_sout_first;
    assign sout_last  = r_sout_last;
    assign busy       = r_busy;

    // State register; reset abandons any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a transfer always lands in SHIFT; the last bit without a transfer ends the word.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_at_last && !w_xfer) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Next values of the datapath and registered outputs.
    // A load puts bit 0 straight onto sout so it appears the cycle after acceptance.
    always_comb begin
        w_shift_next      = '0;
        w_cnt_next        = '0;
        w_sout_next       = 1'b0;
        w_sout_valid_next = 1'b0;
        w_sout_first_next = 1'b0;
        w_sout_last_next  = 1'b0;
        w_busy_next       = 1'b0;
        if (w_xfer) begin
            w_shift_next      = d;
            w_cnt_next        = '0;
            w_sout_next       = d[0];
            w_sout_valid_next = 1'b1;
            w_sout_first_next = 1'b1;
            w_sout_last_next  = (LAST_IDX == CW'(0));
            w_busy_next       = 1'b1;
        end else if ((r_state == ST_SHIFT) && !w_at_last) begin
            w_shift_next      = w_shift_dn;
            w_cnt_next        = w_cnt_inc;
            w_sout_next       = w_shift_dn[0];
            w_sout_valid_next = 1'b1;
            w_sout_first_next = 1'b0;
            w_sout_last_next  = (w_cnt_inc == LAST_IDX);
            w_busy_next       = 1'b1;
        end else begin
            w_shift_next      = '0;
            w_cnt_next        = '0;
            w_sout_next       = 1'b0;
            w_sout_valid_next = 1'b0;
            w_sout_first_next = 1'b0;
            w_sout_last_next  = 1'b0;
            w_busy_next       = 1'b0;
        end
    end

    // Datapath and output registers; all cleared on reset so sout idles at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_sout_first <= 1'b0;
            r_sout_last  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_shift      <= w_shift_next;
            r_cnt        <= w_cnt_next;
            r_sout       <= w_sout_next;
            r_sout_valid <= w_sout_valid_next;
            r_sout_first <= w_sout_first_next;
            r_sout_last  <= w_sout_last_next;
            r_busy       <= w_busy_next;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: an 8-bit and a 1-bit instance.
// A queue-of-bits model predicts every output cycle by cycle. Directed
// scenarios also pin collected words and strobes to literal values.

module tb_word_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] d7;
    logic       d7_valid;
    logic       d7_ready, s7, s7_valid, s7_first, s7_last, b7;
    logic [0:0] d0;
    logic       d0_valid;
    logic       d0_ready, s0, s0_valid, s0_first, s0_last, b0;

    int n_cmp = 0;
    int n_err = 0;

    // Model: queue of pending {bit, first, last}; the head is what sout shows now.
    logic [2:0] q7[$];
    logic [2:0] q0[$];

    word_serializer #(.WIREWIDTH(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .d(d7), .d_valid(d7_valid), .d_ready(d7_ready),
        .sout(s7), .sout_valid(s7_valid), .sout_first(s7_first), .sout_last(s7_last),
        .busy(b7)
    );

    word_serializer #(.WIREWIDTH(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .d(d0), .d_valid(d0_valid), .d_ready(d0_ready),
        .sout(s0), .sout_valid(s0_valid), .sout_first(s0_first), .sout_last(s0_last),
        .busy(b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update for the 8-bit instance: ready while at most one bit remains.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q7.delete();
        end else if (d7_valid && (q7.size() <= 1)) begin
            if (q7.size() > 0) void'(q7.pop_front());
            for (int k = 0; k < 8; k++) q7.push_back({d7[k], 1'(k == 0), 1'(k == 7)});
        end else if (q7.size() > 0) begin
            void'(q7.pop_front());
        end
    end

    // Model update for the 1-bit instance.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q0.delete();
        end else if (d0_valid && (q0.size() <= 1)) begin
            if (q0.size() > 0) void'(q0.pop_front());
            q0.push_back({d0[0], 1'b1, 1'b1});
        end else if (q0.size() > 0) begin
            void'(q0.pop_front());
        end
    end

    // Compare both instances against the model on every falling edge.
    initial forever begin
        logic [2:0] e7;
        logic [2:0] e0;
        @(negedge clk);
        e7 = (q7.size() > 0) ? q7[0] : 3'b000;
        e0 = (q0.size() > 0) ? q0[0] : 3'b000;
        check("w7_sout",  {31'd0, s7},       {31'd0, e7[2]});
        check("w7_first", {31'd0, s7_first}, {31'd0, e7[1]});
        check("w7_last",  {31'd0, s7_last},  {31'd0, e7[0]});
        check("w7_valid", {31'd0, s7_valid}, {31'd0, 1'(q7.size() > 0)});
        check("w7_busy",  {31'd0, b7},       {31'd0, 1'(q7.size() > 0)});
        check("w7_ready", {31'd0, d7_ready}, {31'd0, 1'(q7.size() <= 1)});
        check("w0_sout",  {31'd0, s0},       {31'd0, e0[2]});
        check("w0_first", {31'd0, s0_first}, {31'd0, e0[1]});
        check("w0_last",  {31'd0, s0_last},  {31'd0, e0[0]});
        check("w0_valid", {31'd0, s0_valid}, {31'd0, 1'(q0.size() > 0)});
        check("w0_ready", {31'd0, d0_ready}, {31'd0, 1'(q0.size() <= 1)});
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] data;
        logic [15:0] fmask;
        logic [15:0] lmask;
        logic [2:0]  vals;
        int          nvalid;

        rst_n = 1'b0; d7 = 8'h00; d7_valid = 1'b0; d0 = 1'b0; d0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {27'd0, s7, s7_valid, s7_first, s7_last, b7}, 32'd0);
        check("reset_ready", {31'd0, d7_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Single word 8'hA5 with a one-cycle valid pulse.
        d7 = 8'hA5; d7_valid = 1'b1;
        @(posedge clk); #2; d7_valid = 1'b0; d7 = 8'h00;
        data = '0; fmask = '0; lmask = '0; nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            data[i] = s7; fmask[i] = s7_first; lmask[i] = s7_last;
            if (s7_valid) nvalid++;
        end
        check("a5_bits",  {24'd0, data[7:0]},  32'h0000_00A5);
        check("a5_first", {24'd0, fmask[7:0]}, 32'h0000_0001);
        check("a5_last",  {24'd0, lmask[7:0]}, 32'h0000_0080);
        check("a5_nvalid", nvalid, 32'd8);
        @(negedge clk);
        check("a5_idle_busy",  {31'd0, b7},       32'd0);
        check("a5_idle_ready", {31'd0, d7_ready}, 32'd1);
        @(posedge clk); #2;

        // Back-to-back: 8'h01 then 8'hFF with valid held high.
        d7 = 8'h01; d7_valid = 1'b1;
        @(posedge clk); #2; d7 = 8'hFF;
        data = '0; fmask = '0; nvalid = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            data[i] = s7; fmask[i] = s7_first;
            if (s7_valid) nvalid++;
            if (i == 8) d7_valid = 1'b0;
        end
        check("b2b_bits",   {16'd0, data},  32'h0000_FF01);
        check("b2b_first",  {16'd0, fmask}, 32'h0000_0101);
        check("b2b_nvalid", nvalid, 32'd16);
        @(negedge clk);
        check("b2b_end_valid", {31'd0, s7_valid}, 32'd0);
        @(posedge clk); #2;

        // Hold-off: valid with 8'h3C during bit cycles 2..5 must not load.
        d7 = 8'h96; d7_valid = 1'b1;
        @(posedge clk); #2; d7_valid = 1'b0;
        data = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            data[i] = s7;
            if (i >= 2 && i <= 5) check("hold_ready", {31'd0, d7_ready}, 32'd0);
            if (i == 1) begin d7 = 8'h3C; d7_valid = 1'b1; end
            if (i == 5) d7_valid = 1'b0;
        end
        check("hold_bits", {24'd0, data[7:0]}, 32'h0000_0096);
        @(negedge clk);
        check("hold_no_load", {31'd0, s7_valid}, 32'd0);
        @(posedge clk); #2;

        // Asynchronous reset during bit 4 of 8'hF0.
        d7 = 8'hF0; d7_valid = 1'b1;
        @(posedge clk); #2; d7_valid = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("f0_bit4", {31'd0, s7}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_outputs", {27'd0, s7, s7_valid, s7_first, s7_last, b7}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_valid", {31'd0, s7_valid}, 32'd0);
        end
        @(posedge clk); #2;
        d7 = 8'h0F; d7_valid = 1'b1;
        @(posedge clk); #2; d7_valid = 1'b0;
        data = '0; fmask = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            data[i] = s7; fmask[i] = s7_first;
        end
        check("post_rst_bits",  {24'd0, data[7:0]},  32'h0000_000F);
        check("post_rst_first", {24'd0, fmask[7:0]}, 32'h0000_0001);
        @(posedge clk); #2;

        // One-bit words: 1,0,1 streamed with valid held.
        vals = 3'b101;
        d0 = vals[0]; d0_valid = 1'b1;
        data = '0; fmask = '0; lmask = '0; nvalid = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            if (i < 2) d0 = vals[i + 1];
            else d0_valid = 1'b0;
            @(negedge clk);
            data[i] = s0; fmask[i] = s0_first; lmask[i] = s0_last;
            if (d0_ready) nvalid++;
        end
        check("w0_bits",  {29'd0, data[2:0]},  32'd5);
        check("w0_first", {29'd0, fmask[2:0]}, 32'd7);
        check("w0_last",  {29'd0, lmask[2:0]}, 32'd7);
        check("w0_ready_cnt", nvalid, 32'd3);
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
